// File: rtl/skeleton_echo_buffered.sv
// Buffered echo skeleton: collects up to DEPTH words, applies a selectable
// transform on trigger and hands the results back one word per RD_EN.
module skeleton_echo_buffered #(
  parameter int BITWIDTH_DATA = 16,
  parameter int DEPTH         = 8,
  parameter int BITWIDTH_HEAD = 26
) (
  input  logic                     CLK_SYS,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     WR_EN,
  input  logic [BITWIDTH_DATA-1:0] DATA_IN,
  input  logic [1:0]               MODE,
  input  logic                     TRGG_START_CALC,
  input  logic                     RD_EN,
  output logic [BITWIDTH_DATA-1:0] DATA_OUT,
  output logic [BITWIDTH_HEAD-1:0] DATA_HEAD,
  output logic                     DATA_VALID,
  output logic                     BUSY,
  output logic                     FULL,
  output logic                     OVERFLOW
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [BITWIDTH_DATA-1:0] r_in_buf  [DEPTH];
  logic [BITWIDTH_DATA-1:0] r_out_buf [DEPTH];
  logic [CW-1:0]            r_count, r_idx, r_rd_ptr;
  logic [1:0]               r_mode;
  logic [BITWIDTH_DATA-1:0] r_data_out;
  logic                     r_valid, r_ovf;

  logic                     w_rst, w_wr_ok, w_start, w_last_calc, w_last_rd;
  logic [CW-1:0]            w_count_wr, w_rd_nxt;
  logic [AW-1:0]            w_src_a, w_idx_a, w_cnt_a, w_rd_nxt_a;
  logic [BITWIDTH_DATA-1:0] w_src_word, w_xf;

  assign w_rst       = RST | ~EN;
  assign FULL        = (r_count == CW'(DEPTH));
  assign BUSY        = (r_state == S_CALC);
  assign DATA_OUT    = r_data_out;
  assign DATA_VALID  = r_valid;
  assign OVERFLOW    = r_ovf;
  assign DATA_HEAD   = BITWIDTH_HEAD'({4'd2, 6'(DEPTH), 6'(DEPTH),
                                       5'(BITWIDTH_DATA), 5'(BITWIDTH_DATA)});

  // A write in the trigger cycle lands first, so the start test uses the post-write count
  assign w_wr_ok     = WR_EN && !FULL;
  assign w_count_wr  = r_count + CW'(w_wr_ok);
  assign w_start     = TRGG_START_CALC && (w_count_wr != '0);
  assign w_last_calc = (r_idx == r_count - C_ONE);
  assign w_last_rd   = (r_rd_ptr == r_count - C_ONE);
  assign w_rd_nxt    = r_rd_ptr + C_ONE;

  assign w_idx_a     = AW'(r_idx);
  assign w_cnt_a     = AW'(r_count);
  assign w_rd_nxt_a  = AW'(w_rd_nxt);
  assign w_src_a     = (r_mode == 2'd3) ? AW'(r_count - C_ONE - r_idx) : w_idx_a;
  assign w_src_word  = r_in_buf[w_src_a];

  always_comb begin
    w_xf = w_src_word;
    case (r_mode)
      2'd1:    w_xf = ~w_src_word;
      2'd2:    w_xf = w_src_word + BITWIDTH_DATA'(1);
      default: w_xf = w_src_word;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_CALC;
      S_CALC:  if (w_last_calc) w_state_nxt = S_DONE;
      S_DONE:  if (r_valid && RD_EN && w_last_rd) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_SYS) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Storage arrays are deliberately left uncleared by reset
  always_ff @(posedge CLK_SYS) begin
    if (!w_rst) begin
      if (r_state == S_IDLE && w_wr_ok) r_in_buf[w_cnt_a] <= DATA_IN;
      if (r_state == S_CALC)            r_out_buf[w_idx_a] <= w_xf;
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (w_rst) begin
      r_count    <= '0;
      r_idx      <= '0;
      r_rd_ptr   <= '0;
      r_mode     <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (WR_EN && FULL) r_ovf <= 1'b1;
          r_count <= w_count_wr;
          if (w_start) begin
            r_mode <= MODE;
            r_idx  <= '0;
          end
        end
        S_CALC: r_idx <= r_idx + C_ONE;
        S_DONE: begin
          // First DONE cycle presents word 0, since out_buf[count-1] was only just written
          if (!r_valid) begin
            r_data_out <= r_out_buf[0];
            r_valid    <= 1'b1;
            r_rd_ptr   <= '0;
          end else if (RD_EN) begin
            if (w_last_rd) begin
              r_valid    <= 1'b0;
              r_data_out <= '0;
              r_count    <= '0;
              r_rd_ptr   <= '0;
            end else begin
              r_rd_ptr   <= w_rd_nxt;
              r_data_out <= r_out_buf[w_rd_nxt_a];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
